// File: rtl/oled_line_sched.sv
// oled_line_sched: round-robin scheduler that shares one BCD/char converter
// among N_REQ requesters, each owning one 16-character display line buffer.
module oled_line_sched #(
   parameter int N_REQ       = 4,
   parameter int VAL_W       = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*VAL_W-1:0] req_value,
   input  logic [N_REQ*3-1:0]     req_unit,
   output logic [N_REQ-1:0]       req_ack,
   output logic                   cv_start,
   output logic [VAL_W-1:0]       cv_value,
   output logic [2:0]             cv_unit,
   input  logic                   cv_done,
   input  logic [127:0]           cv_char,
   output logic [N_REQ*128-1:0]   line_char,
   output logic [N_REQ-1:0]       line_upd,
   output logic                   busy,
   output logic [1:0]             err
);
   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int LINE_W = 128;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [IDX_W-1:0]        r_grant, w_grant_nxt;
   logic [IDX_W-1:0]        r_last, w_last_nxt;
   logic [IDX_W-1:0]        w_rr_idx;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic [VAL_W-1:0]        r_value, w_value_nxt, w_req_val;
   logic [2:0]              r_unit, w_unit_nxt, w_req_unit;
   logic [N_REQ-1:0]        r_ack, w_ack_nxt;
   logic [N_REQ-1:0]        r_upd, w_upd_nxt;
   logic                    r_start, w_start_nxt;
   logic                    r_busy, w_busy_nxt;
   logic [1:0]              r_err, w_err_nxt;
   logic [N_REQ*LINE_W-1:0] r_line, w_line_nxt;

   function automatic logic unit_ok(input logic [2:0] u);
      return (u == 3'd1) || (u == 3'd2) || (u == 3'd3) || (u == 3'd6) || (u == 3'd7);
   endfunction

   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] cand;
      pick = last;
      // Scan farthest-to-nearest so the closest requester after 'last' wins.
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(last) + k) % N_REQ);
         if (v[cand]) pick = cand;
      end
      return pick;
   endfunction

   always_comb begin
      w_rr_idx   = rr_pick(req_valid, r_last);
      w_req_val  = '0;
      w_req_unit = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == w_rr_idx) begin
            w_req_val  = req_value[i*VAL_W +: VAL_W];
            w_req_unit = req_unit[i*3 +: 3];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      w_value_nxt = r_value;
      w_unit_nxt  = r_unit;
      w_ack_nxt   = '0;
      w_start_nxt = 1'b0;
      w_upd_nxt   = '0;
      w_err_nxt   = r_err;
      w_line_nxt  = r_line;
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               // Ack and start are registered here so they appear in ISSUE.
               w_grant_nxt         = w_rr_idx;
               w_value_nxt         = w_req_val;
               w_unit_nxt          = w_req_unit;
               w_ack_nxt[w_rr_idx] = 1'b1;
               w_start_nxt         = unit_ok(w_req_unit);
               w_state_nxt         = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (unit_ok(r_unit)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT;
            end else begin
               w_err_nxt[1] = 1'b1;
               w_last_nxt   = r_grant;
               w_state_nxt  = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cv_done) begin
               for (int i = 0; i < N_REQ; i++) begin
                  if (IDX_W'(i) == r_grant) begin
                     w_line_nxt[i*LINE_W +: LINE_W] = cv_char;
                     w_upd_nxt[i]                   = 1'b1;
                  end
               end
               w_state_nxt = S_STORE;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               w_err_nxt[0] = 1'b1;
               w_last_nxt   = r_grant;
               w_state_nxt  = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_STORE: begin
            w_last_nxt  = r_grant;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_last  <= IDX_W'(N_REQ - 1);
         r_cnt   <= '0;
         r_value <= '0;
         r_unit  <= '0;
         r_ack   <= '0;
         r_start <= 1'b0;
         r_upd   <= '0;
         r_busy  <= 1'b0;
         r_err   <= '0;
         r_line  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
         r_value <= w_value_nxt;
         r_unit  <= w_unit_nxt;
         r_ack   <= w_ack_nxt;
         r_start <= w_start_nxt;
         r_upd   <= w_upd_nxt;
         r_busy  <= w_busy_nxt;
         r_err   <= w_err_nxt;
         r_line  <= w_line_nxt;
      end
   end

   assign req_ack   = r_ack;
   assign cv_start  = r_start;
   assign cv_value  = r_value;
   assign cv_unit   = r_unit;
   assign line_char = r_line;
   assign line_upd  = r_upd;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: tb/tb_oled_line_sched.sv
// Testbench for oled_line_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level schedule model.
module tb_oled_line_sched;
   localparam int N  = 4;
   localparam int VW = 32;
   localparam int TO = 256;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic [N-1:0]      req_valid;
   logic [N*VW-1:0]   req_value;
   logic [N*3-1:0]    req_unit;
   logic [N-1:0]      req_ack;
   logic              cv_start;
   logic [VW-1:0]     cv_value;
   logic [2:0]        cv_unit;
   logic              cv_done;
   logic [127:0]      cv_char;
   logic [N*128-1:0]  line_char;
   logic [N-1:0]      line_upd;
   logic              busy;
   logic [1:0]        err;

   oled_line_sched #(.N_REQ(N), .VAL_W(VW), .TIMEOUT_CYC(TO)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .req_valid (req_valid),
      .req_value (req_value),
      .req_unit  (req_unit),
      .req_ack   (req_ack),
      .cv_start  (cv_start),
      .cv_value  (cv_value),
      .cv_unit   (cv_unit),
      .cv_done   (cv_done),
      .cv_char   (cv_char),
      .line_char (line_char),
      .line_upd  (line_upd),
      .busy      (busy),
      .err       (err)
   );

   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;

   // Transaction schedule: cycle numbers at which each visible event is due.
   int           ack_cyc, done_cyc, idle_cyc, err_cyc, wait_end;
   int           g;
   bit           sup;
   logic [1:0]   err_bit;
   logic [VW-1:0] cap_val;
   logic [2:0]   cap_unit;
   logic [127:0] done_char;
   int           m_last;
   logic [127:0] m_line [N];
   logic [1:0]   m_err;

   bit           auto_req, noise, force_done;
   int           force_delay;
   logic [N-1:0] keep_mask;
   int           grant_log[$];
   int           exp_order[5] = '{0, 1, 2, 3, 0};
   int           t0, ack_seen, upd_seen;
   bit           start_seen;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit unit_supported(input logic [2:0] u);
      case (u)
         3'd1, 3'd2, 3'd3, 3'd6, 3'd7: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] rand_unit();
      case ($urandom_range(0, 15))
         0, 1, 2:    return 3'd1;
         3, 4:       return 3'd2;
         5, 6:       return 3'd3;
         7, 8, 9:    return 3'd6;
         10, 11, 12: return 3'd7;
         13:         return 3'd0;
         14:         return 3'd4;
         default:    return 3'd5;
      endcase
   endfunction

   function automatic logic [127:0] rand_char();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [N*128-1:0] pack_lines();
      logic [N*128-1:0] p;
      for (int i = 0; i < N; i++) p[i*128 +: 128] = m_line[i];
      return p;
   endfunction

   task automatic model_reset(input int from_cyc);
      ack_cyc  = -10;
      done_cyc = -10;
      err_cyc  = -10;
      wait_end = -10;
      idle_cyc = from_cyc;
      sup      = 1'b0;
      m_last   = N - 1;
      m_err    = '0;
      for (int i = 0; i < N; i++) m_line[i] = '0;
   endtask

   // One clock: check outputs of this cycle, choose inputs, advance.
   task automatic step();
      logic [N-1:0] exp_ack;
      logic [N-1:0] exp_upd;
      int d;
      int pick;
      if (cyc == err_cyc) m_err = m_err | err_bit;
      exp_ack = '0;
      exp_upd = '0;
      if (cyc == ack_cyc) exp_ack[g] = 1'b1;
      if (sup && cyc == done_cyc + 1) begin
         exp_upd[g] = 1'b1;
         m_line[g]  = done_char;
      end
      chk("req_ack", req_ack, exp_ack);
      chk("cv_start", cv_start, (cyc == ack_cyc) && sup);
      chk("line_upd", line_upd, exp_upd);
      chk("busy", busy, (cyc >= ack_cyc) && (cyc < idle_cyc));
      chk("err", err, m_err);
      if (sup && cyc >= ack_cyc && cyc < idle_cyc) begin
         chk("cv_value", cv_value, cap_val);
         chk("cv_unit", cv_unit, cap_unit);
      end
      if (exp_upd != '0) chk("line_char", line_char, pack_lines());

      if (cyc == ack_cyc) begin
         req_value[g*VW +: VW] = $urandom();
         if (keep_mask[g] || (auto_req && $urandom_range(0, 1) == 1)) begin
            keep_mask[g] = 1'b0;
            if (auto_req) req_unit[g*3 +: 3] = rand_unit();
         end else begin
            req_valid[g] = 1'b0;
         end
      end
      if (auto_req) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               req_valid[i]          = 1'b1;
               req_value[i*VW +: VW] = $urandom();
               req_unit[i*3 +: 3]    = rand_unit();
            end
         end
      end

      if (sys_rst) begin
         model_reset(cyc + 1);
      end else if (cyc >= idle_cyc && req_valid != '0) begin
         pick = -1;
         for (int k = 1; k <= N; k++)
            if (pick < 0 && req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
         g        = pick;
         m_last   = g;
         grant_log.push_back(g);
         cap_val  = req_value[g*VW +: VW];
         cap_unit = req_unit[g*3 +: 3];
         sup      = unit_supported(cap_unit);
         ack_cyc  = cyc + 1;
         if (!sup) begin
            done_cyc = -10;
            wait_end = -10;
            err_cyc  = cyc + 2;
            err_bit  = 2'b10;
            idle_cyc = cyc + 2;
         end else begin
            d = force_delay;
            if (d < 0) d = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 10));
            if (d == 0) begin
               done_cyc = -10;
               err_cyc  = cyc + 2 + TO;
               err_bit  = 2'b01;
               idle_cyc = err_cyc;
               wait_end = err_cyc - 1;
            end else begin
               done_cyc  = cyc + 1 + d;
               done_char = rand_char();
               idle_cyc  = done_cyc + 2;
               wait_end  = done_cyc;
            end
         end
      end

      cv_done = 1'b0;
      if (!sys_rst && cyc == done_cyc) begin
         cv_done = 1'b1;
         cv_char = done_char;
      end else if (force_done ||
                   (noise && !(sup && cyc > ack_cyc && cyc <= wait_end) &&
                    $urandom_range(0, 3) == 0)) begin
         cv_done = 1'b1;
         cv_char = rand_char();
      end
      @(negedge sys_clk);
      cyc++;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      step();
      step();
      sys_rst = 1'b0;
   endtask

   initial begin
      sys_rst     = 1'b1;
      req_valid   = '0;
      req_value   = '0;
      req_unit    = '0;
      cv_done     = 1'b0;
      cv_char     = '0;
      auto_req    = 1'b0;
      noise       = 1'b0;
      force_done  = 1'b0;
      force_delay = -1;
      keep_mask   = '0;
      g           = 0;
      err_bit     = '0;
      cap_val     = '0;
      cap_unit    = '0;
      done_char   = '0;
      cyc         = 0;
      model_reset(1);
      @(negedge sys_clk);
      cyc = 1;

      do_reset();
      chk("rst_cv_value", cv_value, 0);
      chk("rst_cv_unit", cv_unit, 0);
      chk("rst_line_char", line_char, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);

      // Single request on line 2, converter answers 9 cycles after the start.
      req_value[2*VW +: VW] = 32'd12345678;
      req_unit[2*3 +: 3]    = 3'd1;
      req_valid[2]          = 1'b1;
      force_delay           = 9;
      t0 = cyc; ack_seen = -1; upd_seen = -1;
      step();
      while (cyc < idle_cyc) begin
         if (req_ack[2])  ack_seen = cyc;
         if (line_upd[2]) upd_seen = cyc;
         step();
      end
      chk("t1_ack_lat", ack_seen - t0, 1);
      chk("t1_upd_lat", upd_seen - t0, 11);
      chk("t1_line2", line_char[2*128 +: 128], done_char);
      chk("t1_cv_value_held", cv_value, 32'd12345678);

      // All four requesting from reset; requester 0 re-asserts after its ack.
      do_reset();
      grant_log.delete();
      for (int i = 0; i < N; i++) begin
         req_value[i*VW +: VW] = $urandom();
         req_unit[i*3 +: 3]    = 3'd2;
      end
      req_valid   = '1;
      keep_mask   = 4'b0001;
      force_delay = 3;
      for (int k = 0; k < 200 && !(req_valid == '0 && cyc >= idle_cyc); k++) step();
      chk("t2_ngrants", grant_log.size(), 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("t2_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);

      // Unsupported unit code 5 on requester 1.
      req_unit[1*3 +: 3] = 3'd5;
      req_valid[1]       = 1'b1;
      t0 = cyc; ack_seen = -1; start_seen = 1'b0;
      step();
      while (cyc < idle_cyc) begin
         if (req_ack[1]) ack_seen = cyc;
         if (cv_start)   start_seen = 1'b1;
         step();
      end
      chk("t3_ack_cycle", ack_seen - t0, 1);
      chk("t3_no_start", start_seen, 0);
      chk("t3_err", err, 2'b10);
      chk("t3_busy", busy, 0);

      // Converter never answers: timeout after TO cycles in WAIT.
      do_reset();
      req_value[3*VW +: VW] = $urandom();
      req_unit[3*3 +: 3]    = 3'd7;
      req_valid[3]          = 1'b1;
      force_delay           = 0;
      t0 = cyc;
      step();
      while (err[0] == 1'b0 && cyc < t0 + 2 + TO + 50) step();
      chk("t4_timeout_lat", cyc - (t0 + 2), TO);
      chk("t4_busy", busy, 0);
      chk("t4_line3", line_char[3*128 +: 128], 0);
      step();
      chk("t4_err_sticky", err, 2'b01);

      // Reset pulsed mid-WAIT, then a stale cv_done.
      do_reset();
      req_value[0 +: VW] = $urandom();
      req_unit[0 +: 3]   = 3'd2;
      req_valid[0]       = 1'b1;
      force_delay        = 20;
      step();
      repeat (4) step();
      sys_rst = 1'b1;
      step();
      sys_rst    = 1'b0;
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      repeat (3) step();
      chk("t5_line_char", line_char, 0);
      chk("t5_line_upd", line_upd, 0);
      chk("t5_cv_value", cv_value, 0);
      chk("t5_cv_unit", cv_unit, 0);
      chk("t5_busy", busy, 0);
      chk("t5_err", err, 0);

      // Randomized traffic with spurious converter strobes outside WAIT.
      do_reset();
      grant_log.delete();
      auto_req    = 1'b1;
      noise       = 1'b1;
      force_delay = -1;
      repeat (4000) step();
      auto_req = 1'b0;
      for (int k = 0; k < 2000 && !(req_valid == '0 && cyc >= idle_cyc); k++) step();
      chk("rnd_busy_end", busy, 0);
      chk("rnd_lines", line_char, pack_lines());
      chk("rnd_err", err, m_err);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
